// File: rtl/barrel_shifter_8bit_left_pipe_if.sv
// Streaming handshake bundle for barrel_shifter_8bit_left_pipe.
//
// Optional macro: BSL_ROTATE_EN adds the in_rot signal (rotate select).
//
// Signals:
//   in_valid  : upstream -> shifter, in_data/in_ctrl valid this cycle
//   in_ready  : shifter -> upstream, input accepted this cycle
//   in_data   : operand
//   in_ctrl   : left-shift amount, 0..7
//   in_rot    : rotate select (BSL_ROTATE_EN only)
//   out_valid : shifter -> downstream, out_data valid
//   out_ready : downstream -> shifter, out_data consumed this cycle
//   out_data  : shifted result
// Modports: slave = shifter view, master = producer/consumer view.
interface barrel_shifter_8bit_left_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_ctrl;
`ifdef BSL_ROTATE_EN
    logic             in_rot;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_ctrl,
`ifdef BSL_ROTATE_EN
        input  in_rot,
`endif
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_ctrl,
`ifdef BSL_ROTATE_EN
        output in_rot,
`endif
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/barrel_shifter_8bit_left_pipe.sv
// Pipelined 8-bit logical left barrel shifter with valid/ready on both sides.
// Three registered 2:1 mux stages shift by 4, 2 and 1; latency is three clock
// edges counting the accept edge, throughput one item per clock.
//
// Optional macro: BSL_ROTATE_EN turns the zero fill into a rotate when in_rot=1.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : barrel_shifter_8bit_left_pipe_if.slave (in_* / out_* handshake)
module barrel_shifter_8bit_left_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
) (
    input logic                            clk,
    input logic                            rst,
    barrel_shifter_8bit_left_pipe_if.slave bus
);

    logic             en;
    logic [SHW-1:0]   ctrl_in;
    logic             rot_in;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic [1:0]       s1_ctrl_q;
    logic             s1_rot_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_ctrl_q;
    logic             s2_rot_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    logic [WIDTH-1:0] s1_data_d;
    logic [WIDTH-1:0] s2_data_d;
    logic [WIDTH-1:0] out_data_d;
    logic [3:0]       fill1;
    logic [1:0]       fill2;
    logic             fill3;

    assign ctrl_in = bus.in_ctrl;

`ifdef BSL_ROTATE_EN
    assign rot_in = bus.in_rot;
`else
    assign rot_in = 1'b0;
`endif

    // Global stall: the whole pipe moves only when the output slot frees up.
    assign en = !out_valid_q | bus.out_ready;

    // Each stage fills vacated LSBs with zeros, or with the bits shifted out
    // of the top when rotating.
    always_comb begin
        fill1      = rot_in ? bus.in_data[7:4] : 4'b0;
        s1_data_d  = ctrl_in[2] ? {bus.in_data[3:0], fill1} : bus.in_data;
        fill2      = s1_rot_q ? s1_data_q[7:6] : 2'b0;
        s2_data_d  = s1_ctrl_q[1] ? {s1_data_q[5:0], fill2} : s1_data_q;
        fill3      = s2_rot_q ? s2_data_q[7] : 1'b0;
        out_data_d = s2_ctrl_q ? {s2_data_q[6:0], fill3} : s2_data_q;
    end

    // Data registers load only behind a valid so out_data keeps its last
    // result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_ctrl_q   <= '0;
            s1_rot_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_ctrl_q   <= 1'b0;
            s2_rot_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_q <= s1_data_d;
                s1_ctrl_q <= ctrl_in[1:0];
                s1_rot_q  <= rot_in;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_ctrl_q <= s1_ctrl_q[0];
                s2_rot_q  <= s1_rot_q;
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q <= out_data_d;
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_barrel_shifter_8bit_left_pipe.sv
// Directed and random checks for barrel_shifter_8bit_left_pipe.
module tb_barrel_shifter_8bit_left_pipe;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    barrel_shifter_8bit_left_pipe_if bus ();

    barrel_shifter_8bit_left_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] c);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_ctrl  = c;
    endtask

    logic [7:0] sweep_exp [8];
    logic [7:0] q [$];
    logic [7:0] exp_v;
    int         accepted;
    int         emitted;
    int         cycles;

    initial begin
        n_total = 0;
        n_pass  = 0;
        sweep_exp = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        rst = 1'b1;
        drive(1'b0, 8'h00, 3'd0);
`ifdef BSL_ROTATE_EN
        bus.in_rot = 1'b0;
`endif
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        // Single item, latency 3 edges counting the accept edge
        drive(1'b1, 8'hB1, 3'd3);
        step();
        drive(1'b0, 8'h00, 3'd0);
        check("lat_e1_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_e2_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_e3_valid", 32'(bus.out_valid), 32'd1);
        check("lat_e3_data", 32'(bus.out_data), 32'h88);
        step();
        check("lat_after_valid", 32'(bus.out_valid), 32'd0);
        check("lat_hold_data", 32'(bus.out_data), 32'h88);

        // Back-to-back sweep of ctrl on 8'hFF
        for (int n = 1; n <= 10; n++) begin
            if (n <= 8) drive(1'b1, 8'hFF, 3'(n - 1));
            else drive(1'b0, 8'h00, 3'd0);
            step();
            if (n >= 3) begin
                check($sformatf("sweep_valid_%0d", n - 3), 32'(bus.out_valid), 32'd1);
                check($sformatf("sweep_data_%0d", n - 3), 32'(bus.out_data),
                      32'(sweep_exp[n - 3]));
            end
        end
        drive(1'b0, 8'h00, 3'd0);
        step();
        check("sweep_end_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure
        drive(1'b1, 8'h01, 3'd0);
        step();
        drive(1'b1, 8'h01, 3'd1);
        step();
        drive(1'b1, 8'h01, 3'd2);
        step();
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h01, 3'd3);
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_data_%0d", i), 32'(bus.out_data), 32'h01);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_rel_data0", 32'(bus.out_data), 32'h01);
        step();
        drive(1'b0, 8'h00, 3'd0);
        check("bp_rel_data1", 32'(bus.out_data), 32'h02);
        step();
        check("bp_rel_data2", 32'(bus.out_data), 32'h04);
        step();
        check("bp_rel_valid3", 32'(bus.out_valid), 32'd1);
        check("bp_rel_data3", 32'(bus.out_data), 32'h08);
        step();
        check("bp_rel_done", 32'(bus.out_valid), 32'd0);

        // Reset mid-operation, with a handshake offered in the reset cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hAA, 3'(i));
            step();
        end
        rst = 1'b1;
        drive(1'b1, 8'h55, 3'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 3'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("mid_rst_stale_%0d", i), 32'(bus.out_valid), 32'd0);
        end

`ifdef BSL_ROTATE_EN
        // Rotate
        drive(1'b1, 8'hB1, 3'd3);
        bus.in_rot = 1'b1;
        step();
        bus.in_rot = 1'b0;
        step();
        drive(1'b1, 8'h80, 3'd1);
        bus.in_rot = 1'b1;
        step();
        drive(1'b0, 8'h00, 3'd0);
        bus.in_rot = 1'b0;
        check("rot_b1_3", 32'(bus.out_data), 32'h8D);
        step();
        check("shl_b1_3", 32'(bus.out_data), 32'h88);
        step();
        check("rot_80_1", 32'(bus.out_data), 32'h01);
        step();
`endif

        // Random traffic against a queue model
        accepted = 0;
        emitted  = 0;
        cycles   = 0;
        while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
            bus.in_valid  = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_data   = 8'($urandom);
            bus.in_ctrl   = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("rand_extra_output", 32'd1, 32'd0);
                else check("rand_data", 32'(bus.out_data), 32'(q.pop_front()));
                emitted++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_v = bus.in_data << bus.in_ctrl;
                q.push_back(exp_v);
                accepted++;
            end
            step();
            cycles++;
        end
        check("rand_no_timeout", 32'(cycles < 20000), 32'd1);
        check("rand_count", 32'(emitted), 32'(accepted));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
